pe_comp_ctrl_mlane: RTL
=======================

Name: pe_comp_ctrl_mlane

Overview:
Parametrised, multi-lane successor to the PE computation controller. Consumes broadcast activation entries {idx, value} from the PE activation queue. For each entry, it issues beats to the MAC datapath, each beat covering LANES consecutive output activations. Issue uses a valid/ready handshake with backpressure. Sequences layers, flips the activation register-file direction between layers and synchronises on the layer-done flag; sits between the PE activation queue and the PE MAC array.

Parameters:
DATA_W, 16, activation value width
IDX_W, 10, input activation index width
ACT_NO_W, 8, output activation count/address width
LAYER_W, 4, layer count/index width
LANES, 2, output activations processed per beat (power of 2, 1..8)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pe_start_calc  in  1  start network computation
comp_done  in  1  layer done (global sync)
layer_no  in  LAYER_W  total layers
out_act_no  in  ACT_NO_W  output activations per layer
queue_empty  in  1  activation queue empty
act_out  in  IDX_W+DATA_W  queue head {idx, value}
pop_act  out  1  queue pop (combinational)
pe_start_broadcast  out  1  registered 1-cycle pulse at layer start
out_act_clear  out  1  registered 1-cycle pulse at layer start
fin_comp  out  1  broadcast-finished pulse (combinational)
layer_idx  out  LAYER_W  current layer
act_regfile_dir  out  1  register-file direction
busy  out  1  state != IDLE
comp_valid  out  1  beat valid
comp_ready  in  1  datapath accepts beat
in_act_idx  out  IDX_W  beat input index
in_act_value  out  DATA_W  beat input value
out_act_base  out  ACT_NO_W  address of lane 0
lane_mask  out  LANES  per-lane enable

Behaviour:
- Reset: state IDLE; all outputs 0; act_regfile_dir=0; beat counter 0.
- States: IDLE, W_CALC, LAYER_SYNC.
- IDLE: on pe_start_calc, go to W_CALC. Set layer_idx=0 and base=0, and pulse pe_start_broadcast and out_act_clear the next cycle. pe_start_calc in any other state is ignored.
- Output stage is a single register. It can load when ~comp_valid | comp_ready ("slot free"). When not free, all beat outputs hold stable. comp_valid drops the cycle after acceptance if no new beat is loaded.
- W_CALC, per cycle, when ~queue_empty and slot free:
  - head != 0: load beat {idx, value, base, mask}. mask[k] = (base+k < out_act_no); comparison uses ACT_NO_W+1 bits.
    - If base+LANES >= out_act_no: pop_act=1 and base=0.
    - Otherwise base += LANES.
  - head == 0 (end marker): pop_act=1, fin_comp=1, go to LAYER_SYNC. The marker is consumed only when slot free, so every prior beat has been handed off or is being accepted that cycle.
- Queue empty or slot not free: no pop, no state change.
- Beat latency: queue head to comp_valid is 1 cycle.
- out_act_no==0: non-marker entries are popped with no beat issued.
- LAYER_SYNC, on comp_done:
  - If layer_idx == layer_no-1, or layer_no==0: go to IDLE; act_regfile_dir is unchanged.
  - Otherwise: layer_idx+1, act_regfile_dir toggles, base=0, pulse pe_start_broadcast and out_act_clear, go to W_CALC.
  - comp_done outside LAYER_SYNC is ignored.
- Async reset mid-layer aborts immediately. Queued entries are not popped and no pulses are emitted.

Optional Feature:
ZERO_SKIP_EN: when defined, a non-marker entry with value==0 is popped in one cycle without issuing any beat, whatever the base. base stays 0. A slot-free requirement is not needed for the skip. When undefined, zero-valued entries are issued normally, like any other entry.

Test Plan:
- LANES=2, layer_no=1, out_act_no=5, queue {3,7},{0,0}, comp_ready=1 -> beats base 0/2/4, masks 11/11/01. pop on the 3rd beat. Marker pops with fin_comp. comp_done -> IDLE with dir=0.
- Same setup, comp_ready held 0 for 4 cycles at the 2nd beat -> outputs stable, no pop, base 2 beat accepted after release, total 3 beats.
- layer_no=3, marker each layer, comp_done per layer -> layer_idx 0,1,2. dir 0,1,0. Broadcast/clear pulses 3 times. IDLE after the 3rd comp_done.
- queue_empty toggling mid-entry (out_act_no=4, LANES=4) -> single beat mask 1111, no spurious pop.
- rst asserted mid-W_CALC -> all outputs 0 async. Restart via pe_start_calc works from layer 0.
- ZERO_SKIP_EN: entry {5,0} -> popped with no comp_valid. Without the macro -> full beat sequence issued.

Source files
------------

// File: rtl/pe_comp_ctrl_mlane.sv
// Multi-lane PE computation controller: turns activation queue entries
// into MAC beats of LANES outputs each and sequences network layers.
// Optional: define ZERO_SKIP_EN to drop zero-valued entries without a beat.
// Ports:
//   clk, rst (async, active-high)
//   pe_start_calc, comp_done, layer_no, out_act_no  : control / config
//   queue_empty, act_out, pop_act                   : activation queue side
//   pe_start_broadcast, out_act_clear, fin_comp     : layer pulses
//   layer_idx, act_regfile_dir, busy                : status
//   comp_valid/comp_ready, in_act_idx, in_act_value,
//   out_act_base, lane_mask                         : MAC beat handshake
module pe_comp_ctrl_mlane #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 10,
  parameter int ACT_NO_W = 8,
  parameter int LAYER_W  = 4,
  parameter int LANES    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pe_start_calc,
  input  logic                    comp_done,
  input  logic [LAYER_W-1:0]      layer_no,
  input  logic [ACT_NO_W-1:0]     out_act_no,
  input  logic                    queue_empty,
  input  logic [IDX_W+DATA_W-1:0] act_out,
  output logic                    pop_act,
  output logic                    pe_start_broadcast,
  output logic                    out_act_clear,
  output logic                    fin_comp,
  output logic [LAYER_W-1:0]      layer_idx,
  output logic                    act_regfile_dir,
  output logic                    busy,
  output logic                    comp_valid,
  input  logic                    comp_ready,
  output logic [IDX_W-1:0]        in_act_idx,
  output logic [DATA_W-1:0]       in_act_value,
  output logic [ACT_NO_W-1:0]     out_act_base,
  output logic [LANES-1:0]        lane_mask
);

  typedef enum logic [1:0] {
    IDLE,
    W_CALC,
    LAYER_SYNC
  } state_t;

  localparam int EW = ACT_NO_W + 1;
  localparam logic [ACT_NO_W-1:0] STEP = ACT_NO_W'(LANES);

  state_t state, state_nxt;

  logic [ACT_NO_W-1:0] base;
  logic [IDX_W-1:0]    head_idx;
  logic [DATA_W-1:0]   head_val;
  logic [EW-1:0]       base_e;
  logic [EW-1:0]       cnt_e;
  logic [LANES-1:0]    mask_nxt;

  logic slot_free;
  logic is_marker;
  logic skip;
  logic last_beat;
  logic last_layer;
  logic load;
  logic start_layer;
  logic next_layer;

  assign {head_idx, head_val} = act_out;

  assign slot_free = ~comp_valid | comp_ready;
  assign is_marker = (act_out == '0);
  assign base_e    = {1'b0, base};
  assign cnt_e     = {1'b0, out_act_no};
  assign last_beat = (base_e + EW'(LANES)) >= cnt_e;
  assign last_layer = (layer_no == '0) ||
                      (layer_idx == layer_no - LAYER_W'(1));
  assign busy = (state != IDLE);

`ifdef ZERO_SKIP_EN
  // Zero contributions are dropped; they never occupy the output slot.
  assign skip = ~is_marker & (head_val == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    mask_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      mask_nxt[k] = (base_e + EW'(k)) < cnt_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (pe_start_calc) state_nxt = W_CALC;
      W_CALC:     if (fin_comp) state_nxt = LAYER_SYNC;
      LAYER_SYNC: if (comp_done) state_nxt = last_layer ? IDLE : W_CALC;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_act     = 1'b0;
    fin_comp    = 1'b0;
    load        = 1'b0;
    start_layer = 1'b0;
    next_layer  = 1'b0;
    unique case (state)
      IDLE: start_layer = pe_start_calc;
      W_CALC: begin
        if (!queue_empty) begin
          unique case (1'b1)
            is_marker: begin
              // Marker waits for the slot so no beat is left behind.
              pop_act  = slot_free;
              fin_comp = slot_free;
            end
            skip: pop_act = 1'b1;
            default: begin
              if (slot_free) begin
                if (out_act_no == '0) begin
                  pop_act = 1'b1;
                end else begin
                  load    = 1'b1;
                  pop_act = last_beat;
                end
              end
            end
          endcase
        end
      end
      LAYER_SYNC: begin
        next_layer  = comp_done & ~last_layer;
        start_layer = next_layer;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_start_broadcast <= 1'b0;
      out_act_clear      <= 1'b0;
      layer_idx          <= '0;
      act_regfile_dir    <= 1'b0;
      base               <= '0;
      comp_valid         <= 1'b0;
      in_act_idx         <= '0;
      in_act_value       <= '0;
      out_act_base       <= '0;
      lane_mask          <= '0;
    end else begin
      pe_start_broadcast <= start_layer;
      out_act_clear      <= start_layer;
      if (state == IDLE && pe_start_calc) begin
        layer_idx <= '0;
      end else if (next_layer) begin
        layer_idx       <= layer_idx + LAYER_W'(1);
        act_regfile_dir <= ~act_regfile_dir;
      end
      if (start_layer || pop_act) begin
        base <= '0;
      end else if (load) begin
        base <= base + STEP;
      end
      if (load) begin
        comp_valid   <= 1'b1;
        in_act_idx   <= head_idx;
        in_act_value <= head_val;
        out_act_base <= base;
        lane_mask    <= mask_nxt;
      end else if (comp_ready) begin
        comp_valid <= 1'b0;
      end
    end
  end

endmodule
